// File: rtl/iic_pkg.sv
// Shared state encoding and protocol constants for the IIC EEPROM target.
package iic_pkg;

  localparam int unsigned BitsPerByte = 8;
  localparam logic [7:0]  CtrlWrite   = 8'hA0;
  localparam logic [7:0]  CtrlRead    = 8'hA1;

  typedef enum logic [3:0] {
    StIdle,
    StDev,
    StAckDev,
    StAddrHi,
    StAckHi,
    StAddrLo,
    StAckLo,
    StWrData,
    StAckWr,
    StRdData,
    StRdAck,
    StWaitStop
  } iic_state_e;

  // Acknowledge state that follows a fully received byte.
  function automatic iic_state_e ack_state(iic_state_e st);
    case (st)
      StDev:    ack_state = StAckDev;
      StAddrHi: ack_state = StAckHi;
      StAddrLo: ack_state = StAckLo;
      default:  ack_state = StAckWr;
    endcase
  endfunction

endpackage

// File: rtl/iic_slave_eeprom_if.sv
// Byte-wide memory port between the IIC target and its backing storage.
interface iic_slave_eeprom_if;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic        mem_re;
  logic [7:0]  mem_rdata;

  modport master (
    output mem_addr,
    output mem_we,
    output mem_wdata,
    output mem_re,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_we,
    input  mem_wdata,
    input  mem_re,
    output mem_rdata
  );
endinterface

// File: rtl/iic_bus_sync.sv
// Synchronises scl/sda into clk and derives scl edges plus START/STOP conditions.
module iic_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_async,
  input  logic sda_async,
  output logic sda_sync,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_ff_q, scl_ff_d;
  logic [SYNC_STAGES-1:0] sda_ff_q, sda_ff_d;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_sync;

  always_comb begin
    scl_ff_d    = scl_ff_q;
    sda_ff_d    = sda_ff_q;
    scl_ff_d[0] = scl_async;
    sda_ff_d[0] = sda_async;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      scl_ff_d[i] = scl_ff_q[i-1];
      sda_ff_d[i] = sda_ff_q[i-1];
    end
  end

  // Idle bus level is high, so reset to 1 to avoid phantom edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_ff_q   <= '1;
      sda_ff_q   <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_ff_q   <= scl_ff_d;
      sda_ff_q   <= sda_ff_d;
      scl_prev_q <= scl_sync;
      sda_prev_q <= sda_sync;
    end
  end

  always_comb begin
    scl_sync  = scl_ff_q[SYNC_STAGES-1];
    sda_sync  = sda_ff_q[SYNC_STAGES-1];
    scl_rise  = scl_sync & ~scl_prev_q;
    scl_fall  = ~scl_sync & scl_prev_q;
    start_det = scl_sync & scl_prev_q & sda_prev_q & ~sda_sync;
    stop_det  = scl_sync & scl_prev_q & ~sda_prev_q & sda_sync;
  end

endmodule

// File: rtl/iic_slave_eeprom.sv
// IIC target exposing a 16-bit addressed byte memory (24Cxx-style protocol).
module iic_slave_eeprom
  import iic_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               iic_scl,
  inout  wire                sda,
  iic_slave_eeprom_if.master mem,
  output logic               iic_busy
);

  localparam logic [3:0] ByteBits = 4'(BitsPerByte);
  localparam logic [3:0] LastBit  = 4'(BitsPerByte - 1);

  logic sda_sync, scl_rise, scl_fall, start_det, stop_det;

  iic_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_bus_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_async (iic_scl),
    .sda_async (sda),
    .sda_sync  (sda_sync),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  iic_state_e  state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        sda_oe_q, sda_oe_d;
  logic [15:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic        re_q, re_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        inc_q, inc_d;
  logic        load_q, load_d;
  logic [7:0]  byte_in;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    sda_oe_d  = sda_oe_q;
    addr_d    = addr_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    wdata_d   = wdata_q;
    busy_d    = busy_q;
    inc_d     = 1'b0;
    load_d    = re_q;
    byte_in   = {shift_q[6:0], sda_sync};

    // Post-write increment and read-data capture trail their strobes by one clk.
    if (inc_q) addr_d = addr_q + 16'd1;
    if (load_q) shift_d = mem.mem_rdata;

    if (start_det) begin
      state_d   = StDev;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
    end else if (stop_det) begin
      state_d  = StIdle;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StWaitStop: ;
        StDev, StAddrHi, StAddrLo, StWrData: begin
          if (scl_rise && (bit_cnt_q < ByteBits)) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == LastBit) begin
              case (state_q)
                StAddrHi: addr_d[15:8] = byte_in;
                StAddrLo: addr_d[7:0]  = byte_in;
                StWrData: begin
                  wdata_d = byte_in;
                  we_d    = 1'b1;
                  inc_d   = 1'b1;
                end
                default: ;
              endcase
            end
          end else if (scl_fall && (bit_cnt_q == ByteBits)) begin
            bit_cnt_d = '0;
            if ((state_q == StDev) && (shift_q[7:1] != DEV_ADDR)) begin
              state_d = StWaitStop;
            end else begin
              sda_oe_d = 1'b1;
              state_d  = ack_state(state_q);
            end
          end
        end
        StAckDev: begin
          // Reads fetch on the 9th rising edge so the MSB is ready at the ACK's falling edge.
          if (shift_q[0]) begin
            if (scl_rise) begin
              state_d   = StRdData;
              re_d      = 1'b1;
              bit_cnt_d = '0;
            end
          end else if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = StAddrHi;
          end
        end
        StAckHi: if (scl_fall) begin
          sda_oe_d = 1'b0;
          state_d  = StAddrLo;
        end
        StAckLo, StAckWr: if (scl_fall) begin
          sda_oe_d = 1'b0;
          state_d  = StWrData;
        end
        StRdData: if (scl_fall) begin
          if (bit_cnt_q == ByteBits) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = StRdAck;
          end else begin
            sda_oe_d  = ~shift_q[7];
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        StRdAck: if (scl_rise) begin
          if (!sda_sync) begin
            addr_d  = addr_q + 16'd1;
            re_d    = 1'b1;
            state_d = StRdData;
          end else begin
            state_d = StWaitStop;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      sda_oe_q  <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      inc_q     <= 1'b0;
      load_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      sda_oe_q  <= sda_oe_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      re_q      <= re_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
      inc_q     <= inc_d;
      load_q    <= load_d;
    end
  end

  assign sda           = sda_oe_q ? 1'b0 : 1'bz;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_re    = re_q;
  assign iic_busy      = busy_q;

endmodule

// File: tb/tb_iic_slave_eeprom.sv
// Directed bench: bit-banged IIC master plus a tiny memory model around the EEPROM target.
module tb_iic_slave_eeprom;
  import iic_pkg::*;

  localparam int Q = 10;  // clk cycles per half scl period

  logic clk;
  logic rst;
  logic scl;
  logic m_sda_low;
  logic iic_busy;
  wire  sda;

  iic_slave_eeprom_if bus ();

  iic_slave_eeprom #(
    .DEV_ADDR    (7'h50),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .iic_scl  (scl),
    .sda      (sda),
    .mem      (bus),
    .iic_busy (iic_busy)
  );

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered read, contents = low address byte xor 0xD3.
  always @(posedge clk) if (bus.mem_re) bus.mem_rdata <= bus.mem_addr[7:0] ^ 8'hD3;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          we_cnt   = 0;
  int          re_cnt   = 0;
  int          both_cnt = 0;
  logic [15:0] we_addr_log [16];
  logic [7:0]  we_data_log [16];
  logic [15:0] re_addr_log [16];

  always @(negedge clk) begin
    if (bus.mem_we && bus.mem_re) both_cnt++;
    if (bus.mem_we) begin
      if (we_cnt < 16) begin
        we_addr_log[we_cnt] = bus.mem_addr;
        we_data_log[we_cnt] = bus.mem_wdata;
      end
      we_cnt++;
    end
    if (bus.mem_re) begin
      if (re_cnt < 16) re_addr_log[re_cnt] = bus.mem_addr;
      re_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    wait_clks(2);
    m_sda_low = ~b;
    wait_clks(Q);
    scl = 1'b1;
    wait_clks(Q);
    scl = 1'b0;
  endtask

  task automatic i2c_start();
    wait_clks(2);
    m_sda_low = 1'b0;
    wait_clks(Q);
    scl = 1'b1;
    wait_clks(Q);
    m_sda_low = 1'b1;
    wait_clks(Q);
    scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clks(2);
    m_sda_low = 1'b1;
    wait_clks(Q);
    scl = 1'b1;
    wait_clks(Q);
    m_sda_low = 1'b0;
    wait_clks(Q);
  endtask

  // Sends one byte, samples the target's ACK mid-high, then checks the bus is released.
  task automatic wr(input logic [7:0] b, input string tag, input logic exp_ack,
                    input logic chk_rel);
    logic ack;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    wait_clks(2);
    m_sda_low = 1'b0;
    wait_clks(Q);
    scl = 1'b1;
    wait_clks(Q / 2);
    ack = (sda === 1'b0);
    wait_clks(Q / 2);
    scl = 1'b0;
    wait_clks(5);
    check_eq({tag, "_ack"}, 32'(ack), 32'(exp_ack));
    if (chk_rel) check_eq({tag, "_rel"}, 32'(sda === 1'b1), 32'd1);
  endtask

  task automatic rd(output logic [7:0] b, input logic master_ack);
    for (int i = 7; i >= 0; i--) begin
      wait_clks(2);
      m_sda_low = 1'b0;
      wait_clks(Q);
      scl = 1'b1;
      wait_clks(Q / 2);
      b[i] = (sda === 1'b0) ? 1'b0 : 1'b1;
      wait_clks(Q / 2);
      scl = 1'b0;
    end
    wait_clks(4);
    m_sda_low = master_ack;
    wait_clks(Q);
    scl = 1'b1;
    wait_clks(Q);
    scl = 1'b0;
  endtask

  initial begin
    logic [7:0] rbyte;
    int         we_base;
    int         re_base;

    rst       = 1'b1;
    scl       = 1'b1;
    m_sda_low = 1'b0;
    wait_clks(4);
    check_eq("rst_addr", 32'(bus.mem_addr), 32'h0);
    check_eq("rst_we", 32'(bus.mem_we), 32'h0);
    check_eq("rst_re", 32'(bus.mem_re), 32'h0);
    check_eq("rst_wdata", 32'(bus.mem_wdata), 32'h0);
    check_eq("rst_busy", 32'(iic_busy), 32'h0);
    check_eq("rst_sda", 32'(sda === 1'b1), 32'd1);
    rst = 1'b0;
    wait_clks(4);

    // Single byte write 0x5A -> 0x1234.
    i2c_start();
    check_eq("w1_busy", 32'(iic_busy), 32'h1);
    wr(CtrlWrite, "w1_ctrl", 1'b1, 1'b1);
    wr(8'h12, "w1_hi", 1'b1, 1'b1);
    wr(8'h34, "w1_lo", 1'b1, 1'b1);
    wr(8'h5A, "w1_data", 1'b1, 1'b1);
    i2c_stop();
    check_eq("w1_we_cnt", 32'(we_cnt), 32'd1);
    check_eq("w1_we_addr", 32'(we_addr_log[0]), 32'h1234);
    check_eq("w1_we_data", 32'(we_data_log[0]), 32'h5A);
    check_eq("w1_addr_after", 32'(bus.mem_addr), 32'h1235);
    check_eq("w1_busy_end", 32'(iic_busy), 32'h0);

    // Random read at 0x0010 via repeated START; model returns 0x10^0xD3 = 0xC3.
    we_base = we_cnt;
    i2c_start();
    wr(CtrlWrite, "r1_ctrl", 1'b1, 1'b1);
    wr(8'h00, "r1_hi", 1'b1, 1'b1);
    wr(8'h10, "r1_lo", 1'b1, 1'b1);
    i2c_start();
    wr(CtrlRead, "r1_rctrl", 1'b1, 1'b0);
    rd(rbyte, 1'b0);
    check_eq("r1_data", 32'(rbyte), 32'hC3);
    check_eq("r1_re_cnt", 32'(re_cnt), 32'd1);
    check_eq("r1_re_addr", 32'(re_addr_log[0]), 32'h0010);
    check_eq("r1_wait_stop", 32'(dut.state_q), 32'(StWaitStop));
    i2c_stop();
    check_eq("r1_idle", 32'(dut.state_q), 32'(StIdle));
    check_eq("r1_no_we", 32'(we_cnt - we_base), 32'd0);
    check_eq("r1_addr_after", 32'(bus.mem_addr), 32'h0010);

    // Sequential current-address read: 0x10 -> 0xC3, 0x11 -> 0xC2.
    i2c_start();
    wr(CtrlRead, "r2_ctrl", 1'b1, 1'b0);
    rd(rbyte, 1'b1);
    check_eq("r2_data0", 32'(rbyte), 32'hC3);
    rd(rbyte, 1'b0);
    check_eq("r2_data1", 32'(rbyte), 32'hC2);
    i2c_stop();
    check_eq("r2_re_addr1", 32'(re_addr_log[2]), 32'h0011);
    check_eq("r2_addr_after", 32'(bus.mem_addr), 32'h0011);

    // Wrong control byte: no ACK, no strobes.
    we_base = we_cnt;
    re_base = re_cnt;
    i2c_start();
    wr(8'hA2, "bad_ctrl", 1'b0, 1'b1);
    check_eq("bad_busy", 32'(iic_busy), 32'h1);
    i2c_stop();
    check_eq("bad_busy_end", 32'(iic_busy), 32'h0);
    check_eq("bad_no_we", 32'(we_cnt - we_base), 32'd0);
    check_eq("bad_no_re", 32'(re_cnt - re_base), 32'd0);

    // Sequential write across the 0xFFFF wrap.
    we_base = we_cnt;
    i2c_start();
    wr(CtrlWrite, "wrap_ctrl", 1'b1, 1'b1);
    wr(8'hFF, "wrap_hi", 1'b1, 1'b1);
    wr(8'hFF, "wrap_lo", 1'b1, 1'b1);
    wr(8'h11, "wrap_d0", 1'b1, 1'b1);
    wr(8'h22, "wrap_d1", 1'b1, 1'b1);
    i2c_stop();
    check_eq("wrap_we_cnt", 32'(we_cnt - we_base), 32'd2);
    check_eq("wrap_addr0", 32'(we_addr_log[we_base]), 32'hFFFF);
    check_eq("wrap_data0", 32'(we_data_log[we_base]), 32'h11);
    check_eq("wrap_addr1", 32'(we_addr_log[we_base+1]), 32'h0000);
    check_eq("wrap_data1", 32'(we_data_log[we_base+1]), 32'h22);
    check_eq("wrap_addr_after", 32'(bus.mem_addr), 32'h0001);

    // Reset while the target drives the ACK of the low address byte.
    we_base = we_cnt;
    i2c_start();
    wr(CtrlWrite, "rst_ctrl", 1'b1, 1'b1);
    wr(8'h00, "rst_hi", 1'b1, 1'b1);
    for (int i = 7; i >= 0; i--) send_bit(1'b0);
    wait_clks(2);
    m_sda_low = 1'b0;
    wait_clks(4);
    check_eq("rst_ack_lo_state", 32'(dut.state_q), 32'(StAckLo));
    check_eq("rst_ack_lo_drv", 32'(sda === 1'b0), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rst_async_rel", 32'(sda === 1'b1), 32'd1);
    wait_clks(3);
    rst = 1'b0;
    check_eq("rst_mid_busy", 32'(iic_busy), 32'h0);
    check_eq("rst_mid_addr", 32'(bus.mem_addr), 32'h0);
    i2c_stop();
    check_eq("rst_mid_no_we", 32'(we_cnt - we_base), 32'd0);
    i2c_start();
    wr(CtrlWrite, "post_ctrl", 1'b1, 1'b1);
    wr(8'h00, "post_hi", 1'b1, 1'b1);
    wr(8'h40, "post_lo", 1'b1, 1'b1);
    wr(8'h77, "post_data", 1'b1, 1'b1);
    i2c_stop();
    check_eq("post_we_cnt", 32'(we_cnt - we_base), 32'd1);
    check_eq("post_we_addr", 32'(we_addr_log[we_base]), 32'h0040);
    check_eq("post_we_data", 32'(we_data_log[we_base]), 32'h77);

    // STOP in the middle of a data byte.
    we_base = we_cnt;
    i2c_start();
    wr(CtrlWrite, "stp_ctrl", 1'b1, 1'b1);
    wr(8'h00, "stp_hi", 1'b1, 1'b1);
    wr(8'h20, "stp_lo", 1'b1, 1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    i2c_stop();
    check_eq("stp_no_we", 32'(we_cnt - we_base), 32'd0);
    check_eq("stp_idle", 32'(dut.state_q), 32'(StIdle));
    check_eq("stp_busy", 32'(iic_busy), 32'h0);
    check_eq("stp_addr", 32'(bus.mem_addr), 32'h0020);

    check_eq("we_re_exclusive", 32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
